sha3_lane_loader: RTL and testbench
===================================

Name: sha3_lane_loader

Overview:
- Upstream feeder for the round pipeline. Accepts message data one 64-bit lane per cycle with a valid/ready handshake and assembles each rate block into a 5x5 lane matrix.
- Applies SHA-3 multi-rate padding at lane granularity and zero-fills the capacity lanes.
- Presents each assembled block on the same row-vector interface the rounds consume, qualified by a one-cycle good pulse.

Parameters:
- RATE_LANES, 17, lanes per rate block (17 = SHA3-256); legal range 1..24.
- DOMAIN_PAD, 8'h06, domain/pad byte placed after the last message lane (8'h1F for SHAKE).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- idata  in  64  message lane, little-endian lane value.
- ivalid  in  1  idata valid.
- ilast  in  1  qualifies idata as the final lane of the message.
- iready  out  1  loader can accept a lane this cycle.
- osa, osb, osc, osd, ose  out  [63:0] x[0:4] each  rows y=0..4; osa = top row; element x = column.
- good  out  1  one-cycle pulse; matrix outputs valid.
- olast  out  1  valid with good; block is the final block of the message.

Behaviour:
- Reset (rst low, asynchronous): all matrix outputs 0, good 0, olast 0, lane counter 0, state FILL, iready 1 after release. Reset mid-block discards the partial block and emits no good.
- Lane mapping: lane index i = 5*y + x. Lanes 0..4 go to osa[0..4], lanes 5..9 to osb, and so on. Lanes i >= RATE_LANES are always 0.
- Handshake: a lane transfers when ivalid && iready. The lane counter k (0..RATE_LANES-1) increments per transfer and wraps to 0 when a block closes.
- Working registers are separate from output registers, so the first lane of the next block may transfer in the same cycle the previous block is copied out.
- Block close, case 1: transfer with k == RATE_LANES-1 and !ilast. Output registers load the block; good=1 and olast=0 next cycle.
- Block close, case 2: transfer with ilast and k < RATE_LANES-1.
  - Lane k+1 = {56'b0, DOMAIN_PAD}.
  - Lanes k+2..RATE_LANES-1 = 0.
  - Lane RATE_LANES-1 additionally gets bit 63 set (OR with the DOMAIN_PAD value if k+1 == RATE_LANES-1).
  - Output loads next cycle with good=1, olast=1.
- Block close, case 3: transfer with ilast and k == RATE_LANES-1. The current block emits with good=1, olast=0. The FSM then enters PAD for exactly one cycle with iready=0, after which a padding-only block emits with good=1, olast=1:
  - lane 0 = DOMAIN_PAD;
  - lane RATE_LANES-1 |= 1<<63;
  - lanes 0..RATE_LANES-1 otherwise 0.
- RATE_LANES == 1 degenerate cases:
  - ilast on lane 0: case 3.
  - The padding lane in that case is 64'h8000_0000_0000_0000 | DOMAIN_PAD.
- Empty messages are not supported: the first lane must be real data.
- States:
  - FILL: iready=1. Transitions to PAD on case 3, otherwise stays in FILL.
  - PAD: iready=0, one cycle. Returns to FILL.
- Latency: good rises 1 cycle after the closing transfer; 2 cycles for the case-3 padding block.
- good is a single-cycle pulse and never asserts on consecutive cycles except the case-3 pair.
- Matrix outputs hold their value until the next block loads.
- No downstream backpressure: the round pipeline samples every good pulse.
- Working lane registers clear to 0 after every block close, so no stale data leaks into the next block.

Decomposition:
- Shared package sha3_pkg:
  - lane_t (logic[63:0]);
  - row_t (lane_t[0:4]);
  - STATE_LANES = 25;
  - PAD_LAST_BIT = 63;
  - lane-index-to-(row, col) helper function.
- One sub-module is natural: sha3_pad_lane, a combinational generator giving the padded value of lane i from k, ilast, RATE_LANES and DOMAIN_PAD.
- The FSM, counter and registers stay in the top-level module.

Test Plan:
- RATE_LANES=17: lanes 1..17 with ilast on lane 17 -> two good pulses.
  - First block: osa[0]=1 ... osd[1]=17 (lane 16), olast=0.
  - Next good, one cycle after: osa[0]=64'h06, osd[1]=64'h8000_0000_0000_0000, all else 0, olast=1.
  - iready=0 for exactly one cycle.
- 3 lanes A,B,C with ilast on C -> one good 1 cycle later.
  - osa[0..2]=A,B,C; osa[3]=64'h06; osd[1]=64'h8000_0000_0000_0000; lanes 17..24=0; olast=1.
- ilast on lane 16 (k=15) -> lane 16 = 64'h8000_0000_0000_0006.
- Back-to-back: ivalid held high for 34 non-last lanes.
  - iready stays 1 throughout.
  - Two good pulses 17 cycles apart.
  - No lane lost or duplicated.
- Assert rst low after 5 lanes, then release and send 17 lanes -> no good during reset; outputs zero; the next block contains only the post-reset lanes.
- Random ivalid gaps with DOMAIN_PAD=8'h1F -> lane contents match a software reference across 100 messages; the pad byte is 0x1F.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 lane loader: lane/row types, the
// loader FSM encoding and the lane-index to matrix-position mapping.
package sha3_pkg;

    localparam int STATE_LANES  = 25;
    localparam int PAD_LAST_BIT = 63;
    localparam int LANE_IDX_W   = 5;

    typedef logic [63:0] lane_t;
    typedef lane_t [0:4] row_t;

    typedef enum logic {
        ST_FILL,
        ST_PAD
    } state_t;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } lane_pos_t;

    // Lane i = 5*y + x lives in row y, column x.
    function automatic lane_pos_t lane_pos(input int unsigned idx);
        lane_pos_t p;
        p.row = 3'(idx / 5);
        p.col = 3'(idx % 5);
        return p;
    endfunction

endpackage

// File: rtl/sha3_pad_lane.sv
// Padded value of one lane: domain byte at pad_start, bit 63 on the last rate
// lane, zero elsewhere and on every capacity lane.
module sha3_pad_lane
    import sha3_pkg::*;
#(
    parameter int         RATE_LANES = 17,
    parameter logic [7:0] DOMAIN_PAD = 8'h06
) (
    input  logic [LANE_IDX_W-1:0] lane_idx,
    input  logic [LANE_IDX_W-1:0] pad_start,
    output logic [63:0]           pad_lane
);

    localparam logic [LANE_IDX_W-1:0] RATE_K = LANE_IDX_W'(RATE_LANES);
    localparam logic [LANE_IDX_W-1:0] LAST_K = LANE_IDX_W'(RATE_LANES - 1);

    always_comb begin
        pad_lane = '0;
        if (lane_idx < RATE_K) begin
            if (lane_idx == pad_start) pad_lane[7:0] = DOMAIN_PAD;
            if (lane_idx == LAST_K)    pad_lane[PAD_LAST_BIT] = 1'b1;
        end
    end

endmodule

// File: rtl/sha3_lane_loader.sv
// Collects message lanes into SHA-3 rate blocks, applies lane-granular
// multi-rate padding and presents each block as five rows with a good pulse.
module sha3_lane_loader
    import sha3_pkg::*;
#(
    parameter int         RATE_LANES = 17,
    parameter logic [7:0] DOMAIN_PAD = 8'h06
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] idata,
    input  logic        ivalid,
    input  logic        ilast,
    output logic        iready,
    output row_t        osa,
    output row_t        osb,
    output row_t        osc,
    output row_t        osd,
    output row_t        ose,
    output logic        good,
    output logic        olast
);

    localparam logic [LANE_IDX_W-1:0] LAST_K = LANE_IDX_W'(RATE_LANES - 1);

    state_t                state_q, state_d;
    logic [LANE_IDX_W-1:0] k_q, k_d;
    logic                  good_q, good_d;
    logic                  olast_q, olast_d;
    lane_t                 work_q [STATE_LANES];
    lane_t                 work_d [STATE_LANES];
    lane_t                 out_q  [STATE_LANES];
    lane_t                 out_d  [STATE_LANES];
    lane_t                 pad_vec [STATE_LANES];
    logic [LANE_IDX_W-1:0] pad_start;
    logic                  xfer;

    // A padding-only block starts its pad at lane 0; otherwise right after lane k.
    assign pad_start = (state_q == ST_PAD) ? '0 : k_q + LANE_IDX_W'(1);
    assign iready    = (state_q == ST_FILL);
    assign xfer      = ivalid && iready;

    for (genvar g = 0; g < STATE_LANES; g++) begin : g_pad
        sha3_pad_lane #(
            .RATE_LANES (RATE_LANES),
            .DOMAIN_PAD (DOMAIN_PAD)
        ) u_pad (
            .lane_idx  (LANE_IDX_W'(g)),
            .pad_start (pad_start),
            .pad_lane  (pad_vec[g])
        );
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        k_d     = k_q;
        good_d  = 1'b0;
        olast_d = 1'b0;
        work_d  = work_q;
        out_d   = out_q;
        unique case (state_q)
            ST_PAD: begin
                out_d   = pad_vec;
                good_d  = 1'b1;
                olast_d = 1'b1;
                state_d = ST_FILL;
            end
            default: begin
                if (xfer) begin
                    if (ilast || (k_q == LAST_K)) begin
                        for (int i = 0; i < STATE_LANES; i++) begin
                            if (LANE_IDX_W'(i) < k_q)       out_d[i] = work_q[i];
                            else if (LANE_IDX_W'(i) == k_q) out_d[i] = idata;
                            else                            out_d[i] = pad_vec[i];
                        end
                        good_d  = 1'b1;
                        olast_d = (k_q != LAST_K);
                        state_d = (ilast && (k_q == LAST_K)) ? ST_PAD : ST_FILL;
                        k_d     = '0;
                        for (int i = 0; i < STATE_LANES; i++) work_d[i] = '0;
                    end else begin
                        work_d[k_q] = idata;
                        k_d         = k_q + LANE_IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
            k_q     <= '0;
            good_q  <= 1'b0;
            olast_q <= 1'b0;
            // NOTE: lane arrays are reset deliberately: outputs read zero and no stale lane survives.
            for (int i = 0; i < STATE_LANES; i++) begin
                work_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q <= state_d;
            k_q     <= k_d;
            good_q  <= good_d;
            olast_q <= olast_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    row_t      rows [5];
    lane_pos_t pos;

    always_comb begin
        pos = '0;
        for (int r = 0; r < 5; r++) rows[r] = '0;
        for (int i = 0; i < STATE_LANES; i++) begin
            pos = lane_pos(unsigned'(i));
            rows[pos.row][pos.col] = out_q[i];
        end
    end

    assign osa   = rows[0];
    assign osb   = rows[1];
    assign osc   = rows[2];
    assign osd   = rows[3];
    assign ose   = rows[4];
    assign good  = good_q;
    assign olast = olast_q;

endmodule

// File: tb/tb_sha3_lane_loader.sv
// Self-checking bench: two loaders (pad 0x06 and 0x1F) checked every cycle
// against a message-level padding model, plus literal expectations.
module tb_sha3_lane_loader;
    import sha3_pkg::*;

    localparam int R = 17;
    typedef lane_t [0:STATE_LANES-1] mat_t;
    typedef struct packed {
        mat_t        m;
        logic        last;
        logic [31:0] cyc;
    } cap_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    always #5 clk = ~clk;

    logic  ivalid [2];
    logic  ilast  [2];
    lane_t idata  [2];
    logic  iready [2];
    logic  good   [2];
    logic  olast  [2];
    row_t  osa [2], osb [2], osc [2], osd [2], ose [2];

    sha3_lane_loader #(.RATE_LANES(R), .DOMAIN_PAD(8'h06)) u_dut0 (
        .clk(clk), .rst(rst), .idata(idata[0]), .ivalid(ivalid[0]), .ilast(ilast[0]),
        .iready(iready[0]), .osa(osa[0]), .osb(osb[0]), .osc(osc[0]), .osd(osd[0]),
        .ose(ose[0]), .good(good[0]), .olast(olast[0])
    );

    sha3_lane_loader #(.RATE_LANES(R), .DOMAIN_PAD(8'h1F)) u_dut1 (
        .clk(clk), .rst(rst), .idata(idata[1]), .ivalid(ivalid[1]), .ilast(ilast[1]),
        .iready(iready[1]), .osa(osa[1]), .osb(osb[1]), .osc(osc[1]), .osd(osd[1]),
        .ose(ose[1]), .good(good[1]), .olast(olast[1])
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: blocks due next cycle (1) and the cycle after (2).
    mat_t exp1 [2], exp2 [2], shown [2], cur [2];
    bit   v1 [2], v2 [2], l1 [2], l2 [2], rdy_low1 [2];
    int   cur_n [2];
    int   low_cnt [2];
    cap_t cap0 [$];
    cap_t cap1 [$];
    cap_t b0, b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_mat(input string name, input mat_t act, input mat_t exp);
        int bad;
        bad = -1;
        for (int i = 0; i < STATE_LANES; i++)
            if (bad < 0 && act[i] !== exp[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s lane %0d: got %h expected %h", name, bad, act[bad], exp[bad]);
        end
    endtask

    function automatic logic [7:0] pad_of(input int d);
        return (d == 0) ? 8'h06 : 8'h1F;
    endfunction

    // Message-level padding: domain byte right after the data, then bit 63 of the last rate lane.
    function automatic mat_t pad_msg(input mat_t data, input int n, input logic [7:0] pad);
        mat_t m;
        m        = data;
        m[n]     = m[n] ^ {56'b0, pad};
        m[R-1]   = m[R-1] ^ (64'd1 << 63);
        return m;
    endfunction

    function automatic mat_t actual(input int d);
        return {osa[d], osb[d], osc[d], osd[d], ose[d]};
    endfunction

    task automatic monitor(input int d);
        mat_t act, now_m;
        bit   now_v, now_l, now_rdy_low;
        cap_t c;
        act = actual(d);
        if (!rst) begin
            check($sformatf("d%0d good in reset", d), 64'(good[d]), 64'd0);
            check_mat($sformatf("d%0d matrix in reset", d), act, '0);
            v1[d] = 0; v2[d] = 0; rdy_low1[d] = 0;
            cur[d] = '0; cur_n[d] = 0; shown[d] = '0;
            return;
        end
        now_v = v1[d]; now_m = exp1[d]; now_l = l1[d]; now_rdy_low = rdy_low1[d];
        v1[d] = v2[d]; exp1[d] = exp2[d]; l1[d] = l2[d];
        v2[d] = 0; rdy_low1[d] = 0;

        check($sformatf("d%0d good", d), 64'(good[d]), 64'(now_v));
        if (now_v) begin
            check($sformatf("d%0d olast", d), 64'(olast[d]), 64'(now_l));
            check_mat($sformatf("d%0d block", d), act, now_m);
            shown[d] = now_m;
        end else begin
            check_mat($sformatf("d%0d hold", d), act, shown[d]);
        end
        if (good[d]) begin
            c.m = act; c.last = olast[d]; c.cyc = cyc;
            if (d == 0) cap0.push_back(c);
            else        cap1.push_back(c);
        end
        check($sformatf("d%0d iready", d), 64'(iready[d]), 64'(!now_rdy_low));
        if (!iready[d]) low_cnt[d]++;

        if (ivalid[d] && !now_rdy_low) begin
            cur[d][cur_n[d]] = idata[d];
            cur_n[d]++;
            if (cur_n[d] == R) begin
                v1[d] = 1; exp1[d] = cur[d]; l1[d] = 0;
                if (ilast[d]) begin
                    v2[d] = 1; exp2[d] = pad_msg('0, 0, pad_of(d)); l2[d] = 1;
                    rdy_low1[d] = 1;
                end
                cur[d] = '0; cur_n[d] = 0;
            end else if (ilast[d]) begin
                v1[d] = 1; exp1[d] = pad_msg(cur[d], cur_n[d], pad_of(d)); l1[d] = 1;
                cur[d] = '0; cur_n[d] = 0;
            end
        end
    endtask

    task automatic send_lane(input int d, input lane_t v, input bit last, input int gap);
        bit acc;
        int tries;
        repeat (gap) begin
            ivalid[d] = 1'b0;
            idata[d]  = {$urandom, $urandom};
            ilast[d]  = 1'($urandom);
            @(posedge clk); #1;
        end
        ivalid[d] = 1'b1; idata[d] = v; ilast[d] = last;
        acc = 0; tries = 0;
        while (!acc && tries < 8) begin
            @(negedge clk);
            acc = iready[d];
            @(posedge clk); #1;
            tries++;
        end
        ivalid[d] = 1'b0; ilast[d] = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL handshake d%0d: lane not accepted within %0d cycles", d, tries);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, lc, len;
        for (int d = 0; d < 2; d++) begin
            ivalid[d] = 0; ilast[d] = 0; idata[d] = '0;
            v1[d] = 0; v2[d] = 0; l1[d] = 0; l2[d] = 0; rdy_low1[d] = 0;
            exp1[d] = '0; exp2[d] = '0; shown[d] = '0; cur[d] = '0;
            cur_n[d] = 0; low_cnt[d] = 0;
        end
        fork
            forever begin
                @(negedge clk);
                monitor(0);
                monitor(1);
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(1);

        // Full block with ilast on lane 17: data block then padding-only block.
        n0 = cap0.size(); lc = low_cnt[0];
        for (int j = 1; j <= 17; j++) send_lane(0, lane_t'(j), j == 17, 0);
        idle(4);
        check("t1 block count", 64'(cap0.size() - n0), 64'd2);
        check("t1 iready low cycles", 64'(low_cnt[0] - lc), 64'd1);
        if (cap0.size() - n0 == 2) begin
            b0 = cap0[n0]; b1 = cap0[n0+1];
            check("t1 lane0", b0.m[0], 64'd1);
            check("t1 lane16", b0.m[16], 64'd17);
            check("t1 olast first", 64'(b0.last), 64'd0);
            check("t1 pad lane0", b1.m[0], 64'h06);
            check("t1 pad lane1", b1.m[1], 64'h0);
            check("t1 pad lane16", b1.m[16], 64'h8000_0000_0000_0000);
            check("t1 olast pad", 64'(b1.last), 64'd1);
            check("t1 pulse spacing", 64'(b1.cyc - b0.cyc), 64'd1);
        end

        // Short message A,B,C.
        n0 = cap0.size();
        send_lane(0, 64'h0123_4567_89AB_CDEF, 0, 0);
        send_lane(0, 64'hFEDC_BA98_7654_3210, 0, 0);
        send_lane(0, 64'hDEAD_BEEF_CAFE_F00D, 1, 0);
        idle(3);
        check("t2 block count", 64'(cap0.size() - n0), 64'd1);
        if (cap0.size() - n0 == 1) begin
            b0 = cap0[n0];
            check("t2 lane0", b0.m[0], 64'h0123_4567_89AB_CDEF);
            check("t2 lane2", b0.m[2], 64'hDEAD_BEEF_CAFE_F00D);
            check("t2 lane3 pad", b0.m[3], 64'h06);
            check("t2 lane16", b0.m[16], 64'h8000_0000_0000_0000);
            check("t2 lane17", b0.m[17], 64'h0);
            check("t2 lane24", b0.m[24], 64'h0);
            check("t2 olast", 64'(b0.last), 64'd1);
        end

        // ilast on lane 16 (k=15): pad byte and bit 63 share lane 16.
        n0 = cap0.size();
        for (int j = 0; j < 16; j++) send_lane(0, 64'h50 + lane_t'(j), j == 15, 0);
        idle(3);
        check("t3 block count", 64'(cap0.size() - n0), 64'd1);
        if (cap0.size() - n0 == 1) begin
            b0 = cap0[n0];
            check("t3 lane15", b0.m[15], 64'h5F);
            check("t3 lane16", b0.m[16], 64'h8000_0000_0000_0006);
        end

        // Back-to-back: 34 non-last lanes with ivalid held high.
        n0 = cap0.size(); lc = low_cnt[0];
        for (int j = 0; j < 34; j++) send_lane(0, 64'd100 + lane_t'(j), 0, 0);
        idle(3);
        check("t4 block count", 64'(cap0.size() - n0), 64'd2);
        check("t4 iready low cycles", 64'(low_cnt[0] - lc), 64'd0);
        if (cap0.size() - n0 == 2) begin
            b0 = cap0[n0]; b1 = cap0[n0+1];
            check("t4 pulse spacing", 64'(b1.cyc - b0.cyc), 64'd17);
            check("t4 blk0 lane0", b0.m[0], 64'd100);
            check("t4 blk1 lane0", b1.m[0], 64'd117);
            check("t4 blk1 lane16", b1.m[16], 64'd133);
        end

        // Reset after 5 lanes discards them.
        for (int j = 0; j < 5; j++) send_lane(0, 64'hBAD0 + lane_t'(j), 0, 0);
        n0 = cap0.size();
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);
        check("t5 no good in reset", 64'(cap0.size() - n0), 64'd0);
        for (int j = 0; j < 17; j++) send_lane(0, 64'd200 + lane_t'(j), j == 16, 0);
        idle(4);
        check("t5 block count", 64'(cap0.size() - n0), 64'd2);
        if (cap0.size() - n0 == 2) begin
            b0 = cap0[n0];
            check("t5 lane0", b0.m[0], 64'd200);
            check("t5 lane5", b0.m[5], 64'd205);
            check("t5 lane16", b0.m[16], 64'd216);
        end

        // SHAKE pad byte on the second loader.
        n0 = cap1.size();
        send_lane(1, 64'h1111, 0, 0);
        send_lane(1, 64'h2222, 1, 0);
        for (int j = 0; j < 17; j++) send_lane(1, 64'd300 + lane_t'(j), j == 16, 0);
        idle(4);
        check("t6 block count", 64'(cap1.size() - n0), 64'd3);
        if (cap1.size() - n0 == 3) begin
            check("t6 lane2 pad", cap1[n0].m[2], 64'h1F);
            check("t6 lane16", cap1[n0].m[16], 64'h8000_0000_0000_0000);
            check("t6 padblk lane0", cap1[n0+2].m[0], 64'h1F);
            check("t6 padblk lane16", cap1[n0+2].m[16], 64'h8000_0000_0000_0000);
        end

        // 100 random messages with random ivalid gaps.
        for (int m = 0; m < 100; m++) begin
            len = $urandom_range(1, 45);
            for (int j = 0; j < len; j++)
                send_lane(1, {$urandom, $urandom}, j == len - 1,
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
